control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 137 +++++++++++++
 tb/tb_control_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: fetches from an instruction ROM and drives the
// register-file / data-memory / ALU controls. Optional single-step: CONTROL_UNIT_STEP_EN.

`ifndef A_ZERO
`define A_ZERO 4'd0
`endif
`ifndef A_ADD
`define A_ADD 4'd1
`endif
`ifndef A_SUB
`define A_SUB 4'd2
`endif

module control_unit #(
    parameter int WIDTH    = 16,
    parameter int D_ADDR_W = 8,
    parameter int R_ADDR_W = 4,
    parameter int I_ADDR_W = 7
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef CONTROL_UNIT_STEP_EN
    input  logic                step,
`endif
    input  logic [WIDTH-1:0]    instr,
    output logic [I_ADDR_W-1:0] I_addr,
    output logic [D_ADDR_W-1:0] D_addr,
    output logic                D_wr,
    output logic [R_ADDR_W-1:0] RF_W_addr,
    output logic [R_ADDR_W-1:0] RF_A_addr,
    output logic [R_ADDR_W-1:0] RF_B_addr,
    output logic                RF_s,
    output logic                RF_W_en,
    output logic [3:0]          ALU_sel,
    output logic [2:0]          state,
    output logic                halted
);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_LOAD_A = 3'd3;
    localparam logic [2:0] S_LOAD_B = 3'd4;
    localparam logic [2:0] S_STORE  = 3'd5;
    localparam logic [2:0] S_ALU    = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    logic [2:0]          r_state;
    logic [I_ADDR_W-1:0] r_pc;
    logic [WIDTH-1:0]    r_ir;
    logic                w_fetch_go;

`ifdef CONTROL_UNIT_STEP_EN
    assign w_fetch_go = step;
`else
    assign w_fetch_go = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_INIT: r_state <= S_FETCH;
                S_FETCH: begin
                    // PC wraps naturally at 2**I_ADDR_W.
                    if (w_fetch_go) begin
                        r_pc    <= r_pc + I_ADDR_W'(1);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_ir <= instr;
                    case (instr[15:12])
                        OP_LOAD:        r_state <= S_LOAD_A;
                        OP_STORE:       r_state <= S_STORE;
                        OP_ADD, OP_SUB: r_state <= S_ALU;
                        OP_HALT:        r_state <= S_HALT;
                        default:        r_state <= S_FETCH;
                    endcase
                end
                S_LOAD_A: r_state <= S_LOAD_B;
                S_LOAD_B: r_state <= S_FETCH;
                S_STORE:  r_state <= S_FETCH;
                S_ALU:    r_state <= S_FETCH;
                default:  r_state <= S_HALT;
            endcase
        end
    end

    // Controls decode purely from state and IR so reset idles them without a clock.
    always_comb begin
        D_addr    = '0;
        D_wr      = 1'b0;
        RF_W_addr = '0;
        RF_A_addr = '0;
        RF_B_addr = '0;
        RF_s      = 1'b0;
        RF_W_en   = 1'b0;
        ALU_sel   = `A_ZERO;
        case (r_state)
            S_LOAD_A: D_addr = D_ADDR_W'(r_ir[7:0]);
            S_LOAD_B: begin
                D_addr    = D_ADDR_W'(r_ir[7:0]);
                RF_W_addr = R_ADDR_W'(r_ir[11:8]);
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_addr    = D_ADDR_W'(r_ir[7:0]);
                RF_A_addr = R_ADDR_W'(r_ir[11:8]);
                D_wr      = 1'b1;
            end
            S_ALU: begin
                RF_A_addr = R_ADDR_W'(r_ir[7:4]);
                RF_B_addr = R_ADDR_W'(r_ir[3:0]);
                RF_W_addr = R_ADDR_W'(r_ir[11:8]);
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                ALU_sel   = (r_ir[15:12] == OP_SUB) ? `A_SUB : `A_ADD;
            end
            default: ;
        endcase
    end

    assign I_addr = r_pc;
    assign state  = r_state;
    assign halted = (r_state == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a behavioural ROM, data memory, register file
// and ALU around it; expected values are hand-computed constants.

`ifndef A_ZERO
`define A_ZERO 4'd0
`endif
`ifndef A_ADD
`define A_ADD 4'd1
`endif
`ifndef A_SUB
`define A_SUB 4'd2
`endif

module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr;
    logic [6:0]  I_addr;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic [3:0]  RF_W_addr, RF_A_addr, RF_B_addr;
    logic        RF_s, RF_W_en;
    logic [3:0]  ALU_sel;
    logic [2:0]  state;
    logic        halted;
`ifdef CONTROL_UNIT_STEP_EN
    logic        step = 1'b1;
`endif

    logic [15:0] rom [128];
    logic [15:0] mem [256];
    logic [15:0] rf  [16];
    logic [15:0] alu_y;

    logic        pre_mem_we = 1'b0;
    logic        pre_rf_we  = 1'b0;
    logic [7:0]  pre_addr   = '0;
    logic [15:0] pre_data   = '0;

    int total = 0;
    int bad   = 0;

    control_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CONTROL_UNIT_STEP_EN
        .step      (step),
`endif
        .instr     (instr),
        .I_addr    (I_addr),
        .D_addr    (D_addr),
        .D_wr      (D_wr),
        .RF_W_addr (RF_W_addr),
        .RF_A_addr (RF_A_addr),
        .RF_B_addr (RF_B_addr),
        .RF_s      (RF_s),
        .RF_W_en   (RF_W_en),
        .ALU_sel   (ALU_sel),
        .state     (state),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_y = 16'h0000;
        case (ALU_sel)
            `A_ADD:  alu_y = rf[RF_A_addr] + rf[RF_B_addr];
            `A_SUB:  alu_y = rf[RF_A_addr] - rf[RF_B_addr];
            default: alu_y = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        instr <= rom[I_addr];
        if (D_wr)       mem[D_addr] <= rf[RF_A_addr];
        if (RF_W_en)    rf[RF_W_addr] <= RF_s ? alu_y : mem[D_addr];
        if (pre_mem_we) mem[pre_addr] <= pre_data;
        if (pre_rf_we)  rf[pre_addr[3:0]] <= pre_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic poke_mem(input logic [7:0] a, input logic [15:0] d);
        pre_mem_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_mem_we = 1'b0;
    endtask

    task automatic poke_rf(input logic [3:0] a, input logic [15:0] d);
        pre_rf_we = 1'b1; pre_addr = {4'h0, a}; pre_data = d;
        @(posedge clk); #1;
        pre_rf_we = 1'b0;
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    endtask

    task automatic leave_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk(tag, 32'(state), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        int fetches;
        logic [6:0] prev_addr;
        logic wrap_seen;

        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        #1;
        chk("rst_state",   32'(state),   32'd0);
        chk("rst_iaddr",   32'(I_addr),  32'd0);
        chk("rst_dwr",     32'(D_wr),    32'd0);
        chk("rst_rfwen",   32'(RF_W_en), 32'd0);
        chk("rst_halted",  32'(halted),  32'd0);
        chk("rst_alusel",  32'(ALU_sel), 32'(`A_ZERO));

        // HALT only
        enter_reset();
        rom[0] = 16'h5000;
        leave_reset("h_init");
        tick(); chk("h_fetch", 32'(state), 32'd1); chk("h_fetch_pc", 32'(I_addr), 32'd0);
        tick(); chk("h_decode", 32'(state), 32'd2); chk("h_decode_pc", 32'(I_addr), 32'd1);
        tick(); chk("h_halt", 32'(state), 32'd7); chk("h_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("h_hold_state", 32'(state), 32'd7);
            chk("h_hold_pc", 32'(I_addr), 32'd1);
        end

        // LOAD R10,5 then an unassigned opcode (NOOP) then HALT
        enter_reset();
        poke_mem(8'd5, 16'h1234);
        rom[0] = 16'h2A05; rom[1] = 16'h9ABC; rom[2] = 16'h5000;
        leave_reset("l_init");
        tick(); chk("l_fetch", 32'(state), 32'd1);
        tick(); chk("l_decode", 32'(state), 32'd2);
        tick(); chk("l_loada", 32'(state), 32'd3);
        chk("l_loada_daddr", 32'(D_addr), 32'd5);
        chk("l_loada_wen", 32'(RF_W_en), 32'd0);
        tick(); chk("l_loadb", 32'(state), 32'd4);
        chk("l_loadb_wen", 32'(RF_W_en), 32'd1);
        chk("l_loadb_waddr", 32'(RF_W_addr), 32'd10);
        chk("l_loadb_rfs", 32'(RF_s), 32'd0);
        chk("l_loadb_daddr", 32'(D_addr), 32'd5);
        chk("l_loadb_dwr", 32'(D_wr), 32'd0);
        tick(); chk("l_fetch2", 32'(state), 32'd1);
        chk("l_r10", 32'(rf[10]), 32'h1234);
        chk("l_fetch2_wen", 32'(RF_W_en), 32'd0);
        tick(); chk("l_decode2", 32'(state), 32'd2);
        tick(); chk("l_noop_fetch", 32'(state), 32'd1); chk("l_noop_pc", 32'(I_addr), 32'd2);
        tick(); chk("l_decode3", 32'(state), 32'd2);
        tick(); chk("l_halt", 32'(state), 32'd7); chk("l_halt_pc", 32'(I_addr), 32'd3);

        // ADD R3,R1,R2 ; SUB R4,R1,R2 ; HALT
        enter_reset();
        poke_rf(4'd1, 16'd7); poke_rf(4'd2, 16'd9);
        poke_rf(4'd3, 16'd0); poke_rf(4'd4, 16'd0);
        rom[0] = 16'h3312; rom[1] = 16'h4412; rom[2] = 16'h5000;
        leave_reset("a_init");
        tick(); tick();
        tick(); chk("a_alu", 32'(state), 32'd6);
        chk("a_alusel", 32'(ALU_sel), 32'(`A_ADD));
        chk("a_wen", 32'(RF_W_en), 32'd1);
        chk("a_rfs", 32'(RF_s), 32'd1);
        chk("a_waddr", 32'(RF_W_addr), 32'd3);
        chk("a_aaddr", 32'(RF_A_addr), 32'd1);
        chk("a_baddr", 32'(RF_B_addr), 32'd2);
        chk("a_dwr", 32'(D_wr), 32'd0);
        tick(); chk("a_fetch", 32'(state), 32'd1);
        chk("a_alusel_idle", 32'(ALU_sel), 32'(`A_ZERO));
        chk("a_r3", 32'(rf[3]), 32'd16);
        tick();
        tick(); chk("s_alu", 32'(state), 32'd6);
        chk("s_alusel", 32'(ALU_sel), 32'(`A_SUB));
        chk("s_waddr", 32'(RF_W_addr), 32'd4);
        tick(); chk("s_r4", 32'(rf[4]), 32'hFFFE);
        tick();
        tick(); chk("s_halt", 32'(state), 32'd7);

        // STORE R3,255
        enter_reset();
        poke_rf(4'd3, 16'hBEEF); poke_mem(8'd255, 16'h0000);
        rom[0] = 16'h13FF; rom[1] = 16'h5000;
        leave_reset("st_init");
        tick(); chk("st_fetch_dwr", 32'(D_wr), 32'd0);
        tick(); chk("st_decode_dwr", 32'(D_wr), 32'd0);
        tick(); chk("st_state", 32'(state), 32'd5);
        chk("st_dwr", 32'(D_wr), 32'd1);
        chk("st_daddr", 32'(D_addr), 32'd255);
        chk("st_aaddr", 32'(RF_A_addr), 32'd3);
        chk("st_wen", 32'(RF_W_en), 32'd0);
        tick(); chk("st_after_dwr", 32'(D_wr), 32'd0);
        chk("st_mem", 32'(mem[255]), 32'hBEEF);
        tick(); chk("st_decode2_dwr", 32'(D_wr), 32'd0);
        tick(); chk("st_halt", 32'(state), 32'd7);

        // reset pulse while STORE is in progress
        enter_reset();
        poke_rf(4'd3, 16'h5555); poke_mem(8'd255, 16'h0000);
        rom[0] = 16'h13FF; rom[1] = 16'h5000;
        leave_reset("ra_init");
        tick(); tick();
        tick(); chk("ra_store_dwr", 32'(D_wr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ra_dwr_drop", 32'(D_wr), 32'd0);
        chk("ra_state", 32'(state), 32'd0);
        chk("ra_pc", 32'(I_addr), 32'd0);
        @(posedge clk);
        tick(); chk("ra_mem", 32'(mem[255]), 32'h0000);
        rst_n = 1'b1;
        #1 chk("ra_init2", 32'(state), 32'd0);
        tick(); chk("ra_fetch", 32'(state), 32'd1); chk("ra_fetch_pc", 32'(I_addr), 32'd0);
        tick(); chk("ra_decode_pc", 32'(I_addr), 32'd1);

        // NOOP run through two PC wraps, HALT placed at address 0 for the 257th fetch
        enter_reset();
        leave_reset("w_init");
        cycles = 1; fetches = 0; prev_addr = 7'd0; wrap_seen = 1'b0;
        for (int i = 0; i < 1000 && !halted; i++) begin
            tick();
            cycles++;
            if (state == 3'd1) begin
                fetches++;
                if (prev_addr == 7'd127 && I_addr == 7'd0) wrap_seen = 1'b1;
                prev_addr = I_addr;
                if (fetches == 257) rom[0] = 16'h5000;
            end
        end
        chk("w_halted", 32'(halted), 32'd1);
        chk("w_cycles", 32'(cycles), 32'd516);
        chk("w_fetches", 32'(fetches), 32'd257);
        chk("w_wrap", 32'(wrap_seen), 32'd1);
        chk("w_pc", 32'(I_addr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
